id_ex_hazard_reg: RTL and testbench
===================================

// Module: id_ex_hazard_reg
// PURPOSE
//  ID/EX pipeline register for the pipelined OTTER core; sits directly downstream of the instruction decoder.
//  Captures decoder control outputs plus operands, PC, immediate and register addresses each cycle.
//  Detects load-use hazards, inserts bubbles, and requests an IF/ID hold.
//  Applies EX-resolved flushes (taken branch/jump) and keeps saturating stall/flush event counters.
// PARAMETERS
//  XLEN   32  datapath width (PC, operands, immediate)
//  CNT_W  16  width of each performance counter
// PORTS
//  CLK              in   1      clock, rising edge
//  RST_N            in   1      asynchronous active-low reset
//  id_valid         in   1      ID slot holds a real instruction
//  id_pc            in   XLEN   PC of ID instruction
//  id_rs1_addr      in   5      source register 1 index
//  id_rs2_addr      in   5      source register 2 index
//  id_rd_addr       in   5      destination register index
//  id_rs1_used      in   1      instruction reads rs1
//  id_rs2_used      in   1      instruction reads rs2
//  id_rs1_data      in   XLEN   register-file read data 1
//  id_rs2_data      in   XLEN   register-file read data 2
//  id_imm           in   XLEN   selected immediate
//  id_ctrl          in   19     decoder bundle {jump,branch,store,regWrite,memWE2,memRDEN2,alu_fun[3:0],alu_srca[1:0],alu_srcb[2:0],rf_wr_sel[1:0]}
//  ex_hold          in   1      downstream (memory) stall; freeze EX register
//  ex_flush         in   1      EX resolved taken branch/jump; kill ID instruction
//  ex_valid         out  1      EX slot holds a real instruction
//  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out XLEN  registered copies
//  ex_rs1_addr, ex_rs2_addr, ex_rd_addr     out 5     registered copies
//  ex_ctrl          out  19     registered control bundle
//  stall_if_id      out  1      combinational; hold PC and IF/ID this cycle
//  load_use_cnt     out  CNT_W  count of bubbles inserted for load-use hazards
//  flush_cnt        out  CNT_W  count of valid ID instructions killed by flush
// BEHAVIOUR
//  Reset (RST_N=0, async): all ex_* outputs, ex_valid and both counters go to 0 immediately; stall_if_id=0 while in reset.
//  Hazard detection (combinational):
//    load_use = ex_valid & ex_ctrl.memRDEN2 & (ex_rd_addr!=0) & id_valid
//               & ((id_rs1_used & id_rs1_addr==ex_rd_addr) | (id_rs2_used & id_rs2_addr==ex_rd_addr))
//    stall_if_id = ex_hold | (load_use & ~ex_flush)
//  Per-edge update, priority highest first:
//    1 ex_hold=1  -> all EX registers and counters hold; flush and load_use ignored this cycle.
//    2 ex_flush=1 -> bubble: ex_valid=0, all ex_* fields=0; flush_cnt+1 when id_valid=1.
//    3 load_use=1 -> bubble as above; load_use_cnt+1; ID instruction retained upstream via stall_if_id.
//    4 otherwise  -> capture all id_* fields; ex_valid=id_valid. When id_valid=0, ctrl is forced to 0.
//  Latency: 1 cycle from ID to EX. A load-use stall lasts exactly 1 cycle, because the bubble clears ex_valid.
//  Write-enable safety: ex_ctrl.regWrite, memWE2, memRDEN2, jump, branch and store are never 1 when ex_valid=0.
//  x0: rd=0 never triggers a hazard, including a load to x0.
//  Counters saturate at all-ones (no wrap).
//  ex_flush must stay asserted by upstream across ex_hold cycles; its EX source is frozen during the hold.
// TESTING
//  T1 reset mid-run: RST_N low at an arbitrary phase -> ex_valid=0, ex_ctrl=0, counters=0 before the next edge.
//  T2 lw x5 then add x6,x5,x7 -> stall_if_id=1 for 1 cycle, 1 bubble, load_use_cnt=1, add reaches EX 1 cycle late.
//  T3 lw x0 then add x6,x0,x0; lw x5 then addi x6,x8,1 (rs2_used=0, rs2=5) -> no stall, load_use_cnt=0.
//  T4 ex_flush=1 together with load_use=1 -> bubble, stall_if_id=0, flush_cnt=1, load_use_cnt unchanged.
//  T5 ex_hold=1 for 3 cycles with ex_flush=1 -> EX outputs constant; flush applies on the first edge after hold drops.
//  T6 force load_use_cnt to 16'hFFFE, then 3 hazards -> counter reads 16'hFFFF (saturated).

Source files
------------

// File: rtl/id_ex_hazard_reg_if.sv
// ID/EX boundary bundle: decoder-side instruction fields and downstream controls in,
// registered EX slot, IF/ID stall request and event counters out.
interface id_ex_hazard_reg_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [XLEN-1:0]  id_pc;
  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic [4:0]       id_rd_addr;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [XLEN-1:0]  id_rs1_data;
  logic [XLEN-1:0]  id_rs2_data;
  logic [XLEN-1:0]  id_imm;
  logic [18:0]      id_ctrl;
  logic             ex_hold;
  logic             ex_flush;

  logic             ex_valid;
  logic [XLEN-1:0]  ex_pc;
  logic [XLEN-1:0]  ex_rs1_data;
  logic [XLEN-1:0]  ex_rs2_data;
  logic [XLEN-1:0]  ex_imm;
  logic [4:0]       ex_rs1_addr;
  logic [4:0]       ex_rs2_addr;
  logic [4:0]       ex_rd_addr;
  logic [18:0]      ex_ctrl;
  logic             stall_if_id;
  logic [CNT_W-1:0] load_use_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport slave (
    input  id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rd_addr,
           id_rs1_used, id_rs2_used, id_rs1_data, id_rs2_data, id_imm, id_ctrl,
           ex_hold, ex_flush,
    output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_ctrl,
           stall_if_id, load_use_cnt, flush_cnt
  );

  modport master (
    output id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rd_addr,
           id_rs1_used, id_rs2_used, id_rs1_data, id_rs2_data, id_imm, id_ctrl,
           ex_hold, ex_flush,
    input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_ctrl,
           stall_if_id, load_use_cnt, flush_cnt
  );
endinterface

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register for the pipelined OTTER core: load-use bubble insertion,
// EX-resolved flush, IF/ID stall request and saturating stall/flush event counters.
module id_ex_hazard_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  id_ex_hazard_reg_if.slave bus
);

  // The 17 named decoder bits are right-justified; [18:17] are spare and simply carried.
  // Layout: rf_wr_sel[1:0] alu_srcb[4:2] alu_srca[6:5] alu_fun[10:7]
  //         memRDEN2[11] memWE2[12] regWrite[13] store[14] branch[15] jump[16]
  localparam int CTRL_W       = 19;
  localparam int MEMRDEN2_BIT = 11;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [4:0]        rs1_addr;
    logic [4:0]        rs2_addr;
    logic [4:0]        rd_addr;
    logic [CTRL_W-1:0] ctrl;
  } ex_slot_t;

  ex_slot_t         ex_q, ex_d;
  logic [CNT_W-1:0] load_use_cnt_q, load_use_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic ex_is_load;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
  endfunction

  // A load writing x0 never produces a value anyone can depend on.
  always_comb begin
    ex_is_load = ex_q.valid & ex_q.ctrl[MEMRDEN2_BIT] & (ex_q.rd_addr != 5'd0);
    rs1_hit    = bus.id_rs1_used & (bus.id_rs1_addr == ex_q.rd_addr);
    rs2_hit    = bus.id_rs2_used & (bus.id_rs2_addr == ex_q.rd_addr);
    load_use   = ex_is_load & bus.id_valid & (rs1_hit | rs2_hit);
  end

  assign bus.stall_if_id = RST_N & (bus.ex_hold | (load_use & ~bus.ex_flush));

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    ex_d           = ex_q;
    load_use_cnt_d = load_use_cnt_q;
    flush_cnt_d    = flush_cnt_q;

    if (!bus.ex_hold) begin
      if (bus.ex_flush) begin
        ex_d = '0;
        if (bus.id_valid) flush_cnt_d = sat_inc(flush_cnt_q);
      end else if (load_use) begin
        ex_d           = '0;
        load_use_cnt_d = sat_inc(load_use_cnt_q);
      end else begin
        ex_d.valid    = bus.id_valid;
        ex_d.pc       = bus.id_pc;
        ex_d.rs1_data = bus.id_rs1_data;
        ex_d.rs2_data = bus.id_rs2_data;
        ex_d.imm      = bus.id_imm;
        ex_d.rs1_addr = bus.id_rs1_addr;
        ex_d.rs2_addr = bus.id_rs2_addr;
        ex_d.rd_addr  = bus.id_rd_addr;
        // Write enables must never ride along with an empty slot.
        ex_d.ctrl     = bus.id_valid ? bus.id_ctrl : '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ex_q           <= '0;
      load_use_cnt_q <= '0;
      flush_cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      ex_q           <= ex_d;
      load_use_cnt_q <= load_use_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  assign bus.ex_valid     = ex_q.valid;
  assign bus.ex_pc        = ex_q.pc;
  assign bus.ex_rs1_data  = ex_q.rs1_data;
  assign bus.ex_rs2_data  = ex_q.rs2_data;
  assign bus.ex_imm       = ex_q.imm;
  assign bus.ex_rs1_addr  = ex_q.rs1_addr;
  assign bus.ex_rs2_addr  = ex_q.rs2_addr;
  assign bus.ex_rd_addr   = ex_q.rd_addr;
  assign bus.ex_ctrl      = ex_q.ctrl;
  assign bus.load_use_cnt = load_use_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Bench for id_ex_hazard_reg: directed hazard/flush/hold/reset scenarios plus random traffic,
// checked every cycle against an instruction-slot model; a 3-bit-counter twin exercises saturation.
module tb_id_ex_hazard_reg;

  localparam logic [18:0] C_LOAD = 19'h02800;  // memRDEN2 | regWrite
  localparam logic [18:0] C_ALU  = 19'h02000;  // regWrite

  logic CLK;
  logic RST_N;

  id_ex_hazard_reg_if #(.XLEN(32), .CNT_W(16)) a_if ();
  id_ex_hazard_reg_if #(.XLEN(32), .CNT_W(3))  b_if ();

  id_ex_hazard_reg #(.XLEN(32), .CNT_W(16)) dut_a (.CLK(CLK), .RST_N(RST_N), .bus(a_if));
  id_ex_hazard_reg #(.XLEN(32), .CNT_W(3))  dut_b (.CLK(CLK), .RST_N(RST_N), .bus(b_if));

  assign b_if.id_valid    = a_if.id_valid;
  assign b_if.id_pc       = a_if.id_pc;
  assign b_if.id_rs1_addr = a_if.id_rs1_addr;
  assign b_if.id_rs2_addr = a_if.id_rs2_addr;
  assign b_if.id_rd_addr  = a_if.id_rd_addr;
  assign b_if.id_rs1_used = a_if.id_rs1_used;
  assign b_if.id_rs2_used = a_if.id_rs2_used;
  assign b_if.id_rs1_data = a_if.id_rs1_data;
  assign b_if.id_rs2_data = a_if.id_rs2_data;
  assign b_if.id_imm      = a_if.id_imm;
  assign b_if.id_ctrl     = a_if.id_ctrl;
  assign b_if.ex_hold     = a_if.ex_hold;
  assign b_if.ex_flush    = a_if.ex_flush;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // What the EX slot must contain: an instruction or a bubble (all zero).
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [18:0] ctrl;
  } slot_t;

  slot_t m;
  int    m_lu;
  int    m_fl;
  int    checks;
  int    failures;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input int n, input int w);
    longint lim = (longint'(1) << w) - 1;
    return (longint'(n) > lim) ? lim : longint'(n);
  endfunction

  // A dependent consumer of a real, non-x0 load currently in EX must wait a cycle.
  function automatic bit exp_load_use();
    bit dep;
    dep = (a_if.id_rs1_used && a_if.id_rs1_addr == m.rd) ||
          (a_if.id_rs2_used && a_if.id_rs2_addr == m.rd);
    return m.valid && m.ctrl[11] && (m.rd != 5'd0) && a_if.id_valid && dep;
  endfunction

  function automatic bit exp_stall();
    return RST_N && (a_if.ex_hold || (exp_load_use() && !a_if.ex_flush));
  endfunction

  task automatic model_step();
    if (!RST_N || a_if.ex_hold) return;
    if (a_if.ex_flush) begin
      m = '0;
      if (a_if.id_valid) m_fl++;
    end else if (exp_load_use()) begin
      m = '0;
      m_lu++;
    end else begin
      m.valid = a_if.id_valid;
      m.pc    = a_if.id_pc;
      m.rs1d  = a_if.id_rs1_data;
      m.rs2d  = a_if.id_rs2_data;
      m.imm   = a_if.id_imm;
      m.rs1   = a_if.id_rs1_addr;
      m.rs2   = a_if.id_rs2_addr;
      m.rd    = a_if.id_rd_addr;
      m.ctrl  = a_if.id_valid ? a_if.id_ctrl : 19'h0;
    end
  endtask

  always @(negedge CLK) begin
    check("ex_valid",   a_if.ex_valid,    m.valid);
    check("ex_pc",      a_if.ex_pc,       m.pc);
    check("ex_rs1_data", a_if.ex_rs1_data, m.rs1d);
    check("ex_rs2_data", a_if.ex_rs2_data, m.rs2d);
    check("ex_imm",     a_if.ex_imm,      m.imm);
    check("ex_rs1_addr", a_if.ex_rs1_addr, m.rs1);
    check("ex_rs2_addr", a_if.ex_rs2_addr, m.rs2);
    check("ex_rd_addr", a_if.ex_rd_addr,  m.rd);
    check("ex_ctrl",    a_if.ex_ctrl,     m.ctrl);
    check("stall_if_id", a_if.stall_if_id, exp_stall());
    check("load_use_cnt", a_if.load_use_cnt, sat(m_lu, 16));
    check("flush_cnt",  a_if.flush_cnt,   sat(m_fl, 16));
    check("b_ex_valid", b_if.ex_valid,    m.valid);
    check("b_stall",    b_if.stall_if_id, exp_stall());
    check("b_load_use_cnt", b_if.load_use_cnt, sat(m_lu, 3));
    check("b_flush_cnt", b_if.flush_cnt,  sat(m_fl, 3));
  end

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic set_id(input bit v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input bit u1,
                        input bit u2, input logic [18:0] ctrl);
    a_if.id_valid    = v;
    a_if.id_pc       = pc;
    a_if.id_rs1_addr = rs1;
    a_if.id_rs2_addr = rs2;
    a_if.id_rd_addr  = rd;
    a_if.id_rs1_used = u1;
    a_if.id_rs2_used = u2;
    a_if.id_rs1_data = $urandom;
    a_if.id_rs2_data = $urandom;
    a_if.id_imm      = $urandom;
    a_if.id_ctrl     = ctrl;
  endtask

  task automatic rand_id();
    set_id(($urandom % 8) != 0, $urandom, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           19'($urandom));
  endtask

  task automatic mid_reset();
    a_if.ex_hold = 1'b1;
    #($urandom_range(1, 7));
    RST_N = 1'b0;
    m     = '0;
    m_lu  = 0;
    m_fl  = 0;
    #1;
    check("T1 ex_valid", a_if.ex_valid, 1'b0);
    check("T1 ex_ctrl", a_if.ex_ctrl, 19'h0);
    check("T1 load_use_cnt", a_if.load_use_cnt, 16'h0);
    check("T1 flush_cnt", a_if.flush_cnt, 16'h0);
    check("T1 stall_if_id", a_if.stall_if_id, 1'b0);
    @(negedge CLK);
    #2;
    RST_N = 1'b1;
  endtask

  task automatic random_run(input int n);
    bit stalled;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      stalled = a_if.stall_if_id;
      tick();
      if (!stalled) rand_id();
      if (a_if.ex_hold && a_if.ex_flush) a_if.ex_flush = 1'b1;
      else a_if.ex_flush = ($urandom % 10) == 0;
      a_if.ex_hold = ($urandom % 8) == 0;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m        = '0;
    m_lu     = 0;
    m_fl     = 0;
    RST_N    = 1'b0;
    a_if.ex_hold  = 1'b0;
    a_if.ex_flush = 1'b0;
    set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 19'h0);
    #12;
    RST_N = 1'b1;
    #1;
    check("reset ex_valid", a_if.ex_valid, 1'b0);
    check("reset load_use_cnt", a_if.load_use_cnt, 16'h0);

    // T2: lw x5 ; add x6,x5,x7
    set_id(1'b1, 32'h0000_0010, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LOAD);
    tick();
    set_id(1'b1, 32'h0000_0014, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, C_ALU);
    #1;
    check("T2 stall", a_if.stall_if_id, 1'b1);
    tick();
    check("T2 bubble", a_if.ex_valid, 1'b0);
    check("T2 load_use_cnt", a_if.load_use_cnt, 16'd1);
    check("T2 stall released", a_if.stall_if_id, 1'b0);
    tick();
    check("T2 add valid", a_if.ex_valid, 1'b1);
    check("T2 add pc", a_if.ex_pc, 32'h0000_0014);
    check("T2 add rd", a_if.ex_rd_addr, 5'd6);

    // T3: lw x0 ; add x6,x0,x0  and  lw x5 ; addi x6,x8,1 with rs2=5 unused
    set_id(1'b1, 32'h0000_0020, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, C_LOAD);
    tick();
    set_id(1'b1, 32'h0000_0024, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, C_ALU);
    #1;
    check("T3 x0 no stall", a_if.stall_if_id, 1'b0);
    tick();
    check("T3 x0 add captured", a_if.ex_pc, 32'h0000_0024);
    set_id(1'b1, 32'h0000_0028, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LOAD);
    tick();
    set_id(1'b1, 32'h0000_002c, 5'd8, 5'd5, 5'd6, 1'b1, 1'b0, C_ALU);
    #1;
    check("T3 unused rs2 no stall", a_if.stall_if_id, 1'b0);
    tick();
    check("T3 addi captured", a_if.ex_pc, 32'h0000_002c);
    check("T3 load_use_cnt unchanged", a_if.load_use_cnt, 16'd1);

    // T4: flush together with a load-use hazard
    set_id(1'b1, 32'h0000_0200, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LOAD);
    tick();
    set_id(1'b1, 32'h0000_0204, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, C_ALU);
    a_if.ex_flush = 1'b1;
    #1;
    check("T4 stall suppressed", a_if.stall_if_id, 1'b0);
    tick();
    a_if.ex_flush = 1'b0;
    check("T4 bubble", a_if.ex_valid, 1'b0);
    check("T4 flush_cnt", a_if.flush_cnt, 16'd1);
    check("T4 load_use_cnt", a_if.load_use_cnt, 16'd1);

    // T5: hold for 3 cycles with flush asserted throughout
    set_id(1'b1, 32'h0000_0100, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, C_ALU);
    tick();
    a_if.ex_hold  = 1'b1;
    a_if.ex_flush = 1'b1;
    set_id(1'b1, 32'h0000_0104, 5'd3, 5'd4, 5'd10, 1'b1, 1'b1, C_ALU);
    #1;
    check("T5 stall on hold", a_if.stall_if_id, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("T5 held pc", a_if.ex_pc, 32'h0000_0100);
      check("T5 held valid", a_if.ex_valid, 1'b1);
      check("T5 flush_cnt held", a_if.flush_cnt, 16'd1);
    end
    a_if.ex_hold = 1'b0;
    tick();
    a_if.ex_flush = 1'b0;
    check("T5 flushed", a_if.ex_valid, 1'b0);
    check("T5 flush_cnt", a_if.flush_cnt, 16'd2);

    // T6: self-dependent load repeated: a hazard every other cycle, 8 in total
    set_id(1'b1, 32'h0000_0300, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, C_LOAD);
    repeat (16) tick();
    check("T6 load_use_cnt 16b", a_if.load_use_cnt, 16'd9);
    check("T6 load_use_cnt saturated 3b", b_if.load_use_cnt, 3'h7);
    check("T6 flush_cnt 3b", b_if.flush_cnt, 3'd2);

    random_run(3000);
    mid_reset();
    random_run(1500);

    @(negedge CLK);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
